// File: rtl/jsilicon_pkg.sv
// Shared types and ASCII constants for the result-to-UART text framer.
package jsilicon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        OPC,
        SEP,
        HEX,
        CR,
        LF,
        DONE
    } framer_state_e;

    localparam logic [7:0] ASCII_R       = 8'h52;
    localparam logic [7:0] ASCII_COLON   = 8'h3A;
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational mapping of one hex nibble to its ASCII digit.
module nibble_to_ascii
    import jsilicon_pkg::*;
#(
    parameter bit UPPERCASE = 1'b1
) (
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    localparam logic [7:0] LETTER_BASE = UPPERCASE ? ASCII_UPPER_A : ASCII_LOWER_A;

    always_comb begin
        if (nibble_i < 4'd10) begin
            ascii_o = ASCII_ZERO + {4'b0000, nibble_i};
        end else begin
            ascii_o = LETTER_BASE + {4'b0000, nibble_i} - 8'd10;
        end
    end

endmodule

// File: rtl/result_framer.sv
// Captures one ALU result and streams it to the UART as "R<op>:<hex>[CR LF]".
module result_framer
    import jsilicon_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter bit          UPPERCASE = 1'b1,
    parameter bit          SEND_CRLF = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              result_valid,
    input  logic [DATA_W-1:0] result,
    input  logic [2:0]        opcode,
    output logic              result_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned     NIBBLES  = DATA_W / 4;
    localparam int unsigned     CNT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    framer_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [2:0]        opc_q, opc_d;

    logic              result_ready_q, result_ready_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic              capture;
    logic              xfer;
    logic [3:0]        hex_nibble;
    logic [7:0]        hex_ascii;

    assign capture = result_valid && result_ready_q;
    assign xfer    = tx_valid_q && tx_ready;

    // Outputs are registered from the next state, so each byte appears right after the edge that selects it.
    assign hex_nibble = 4'(res_q >> {cnt_d, 2'b00});

    nibble_to_ascii #(.UPPERCASE(UPPERCASE)) u_hex (
        .nibble_i (hex_nibble),
        .ascii_o  (hex_ascii)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            res_q          <= '0;
            opc_q          <= '0;
            result_ready_q <= 1'b0;
            tx_valid_q     <= 1'b0;
            tx_data_q      <= '0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            res_q          <= res_d;
            opc_q          <= opc_d;
            result_ready_q <= result_ready_d;
            tx_valid_q     <= tx_valid_d;
            tx_data_q      <= tx_data_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        opc_d   = opc_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (capture) begin
                    state_d = HDR;
                    res_d   = result;
                    opc_d   = opcode;
                end
            end
            HDR: if (xfer) state_d = OPC;
            OPC: if (xfer) state_d = SEP;
            SEP: begin
                if (xfer) begin
                    state_d = HEX;
                    cnt_d   = CNT_LAST;
                end
            end
            HEX: begin
                if (xfer) begin
                    if (cnt_q == '0) begin
                        state_d = SEND_CRLF ? CR : DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            CR:      if (xfer) state_d = LF;
            LF:      if (xfer) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        result_ready_d = 1'b0;
        tx_valid_d     = 1'b1;
        tx_data_d      = '0;
        busy_d         = 1'b1;
        frame_done_d   = 1'b0;
        case (state_d)
            IDLE: begin
                result_ready_d = 1'b1;
                tx_valid_d     = 1'b0;
                busy_d         = 1'b0;
            end
            DONE: begin
                result_ready_d = 1'b1;
                tx_valid_d     = 1'b0;
                busy_d         = 1'b0;
                frame_done_d   = 1'b1;
            end
            HDR:     tx_data_d = ASCII_R;
            OPC:     tx_data_d = ASCII_ZERO + {5'b00000, opc_q};
            SEP:     tx_data_d = ASCII_COLON;
            HEX:     tx_data_d = hex_ascii;
            CR:      tx_data_d = ASCII_CR;
            LF:      tx_data_d = ASCII_LF;
            default: tx_data_d = '0;
        endcase
    end

    assign result_ready = result_ready_q;
    assign tx_valid     = tx_valid_q;
    assign tx_data      = tx_data_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_result_framer.sv
// Directed and randomized frames checked against a text-level model of the frame format.
module tb_result_framer;

    typedef logic [7:0] bq_t[$];

    logic        clock = 1'b0;
    logic        reset;

    logic        rv, rr, txv, txr, busy, fd;
    logic [15:0] res;
    logic [2:0]  op;
    logic [7:0]  txd;

    logic        rv8, rr8, txv8, txr8, busy8, fd8;
    logic [7:0]  res8;
    logic [2:0]  op8;
    logic [7:0]  txd8;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    result_framer #(.DATA_W(16), .UPPERCASE(1'b1), .SEND_CRLF(1'b1)) dut (
        .clock(clock), .reset(reset), .result_valid(rv), .result(res), .opcode(op),
        .result_ready(rr), .tx_data(txd), .tx_valid(txv), .tx_ready(txr),
        .busy(busy), .frame_done(fd)
    );

    result_framer #(.DATA_W(8), .UPPERCASE(1'b0), .SEND_CRLF(1'b0)) dut8 (
        .clock(clock), .reset(reset), .result_valid(rv8), .result(res8), .opcode(op8),
        .result_ready(rr8), .tx_data(txd8), .tx_valid(txv8), .tx_ready(txr8),
        .busy(busy8), .frame_done(fd8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame text built straight from the format: 'R', op digit, ':', hex digits MSB first, optional CR LF.
    function automatic bq_t model(input logic [15:0] r, input logic [2:0] o, input int w,
                                  input bit up, input bit crlf);
        bq_t        q;
        string      hx;
        logic [7:0] zero_c;
        zero_c = "0";
        hx = up ? "0123456789ABCDEF" : "0123456789abcdef";
        q.push_back("R");
        q.push_back(zero_c + {5'd0, o});
        q.push_back(":");
        for (int i = w / 4 - 1; i >= 0; i--) begin
            q.push_back(hx[int'((r >> (4 * i)) & 16'hF)]);
        end
        if (crlf) begin
            q.push_back(8'd13);
            q.push_back(8'd10);
        end
        return q;
    endfunction

    task automatic run_frame(input logic [15:0] r, input logic [2:0] o,
                             input int stall_at, input int stall_len,
                             input int pend_at, input logic [15:0] pend_r, input logic [2:0] pend_o,
                             input string tag);
        bq_t exp, got;
        int  idx        = 0;
        int  stall_left = stall_len;
        int  cyc        = 0;
        exp = model(r, o, 16, 1'b1, 1'b1);
        chk({tag, "/ready_pre"}, rr, 1);
        rv = 1'b1; res = r; op = o; txr = 1'b1;
        @(posedge clock); #1;
        rv = 1'b0;
        chk({tag, "/busy_cap"}, busy, 1);
        chk({tag, "/ready_cap"}, rr, 0);
        chk({tag, "/valid_cap"}, txv, 1);
        chk({tag, "/done_low"}, fd, 0);
        while (fd !== 1'b1 && cyc < 60) begin
            if (pend_at >= 0 && idx == pend_at) begin
                rv = 1'b1; res = pend_r; op = pend_o;
            end
            if (pend_at >= 0 && idx >= pend_at) chk({tag, "/reject"}, rr, 0);
            if (idx == stall_at && stall_left > 0) begin
                txr = 1'b0;
                chk($sformatf("%s/hold_valid%0d", tag, stall_left), txv, 1);
                chk($sformatf("%s/hold_data%0d", tag, stall_left), txd, exp[idx]);
                stall_left--;
            end else begin
                txr = 1'b1;
                if (txv === 1'b1) begin
                    got.push_back(txd);
                    idx++;
                end
            end
            @(posedge clock); #1;
            cyc++;
        end
        txr = 1'b1;
        chk({tag, "/frame_done"}, fd, 1);
        chk({tag, "/cycles"}, cyc, exp.size() + stall_len);
        chk({tag, "/nbytes"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) chk($sformatf("%s/byte%0d", tag, i), got[i], exp[i]);
        end
        chk({tag, "/idle_valid"}, txv, 0);
        chk({tag, "/idle_busy"}, busy, 0);
        chk({tag, "/idle_ready"}, rr, 1);
    endtask

    initial begin
        bq_t         exp, got;
        logic [15:0] r;
        logic [2:0]  o;
        logic [7:0]  r8;
        int          cyc;

        reset = 1'b1;
        rv = 1'b0; res = '0; op = '0; txr = 1'b0;
        rv8 = 1'b0; res8 = '0; op8 = '0; txr8 = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst/ready", rr, 0);
        chk("rst/valid", txv, 0);
        chk("rst/data", txd, 0);
        chk("rst/busy", busy, 0);
        chk("rst/done", fd, 0);
        chk("rst8/ready", rr8, 0);
        chk("rst8/valid", txv8, 0);
        chk("rst8/busy", busy8, 0);
        reset = 1'b0;
        #1;
        chk("rel/ready", rr, 0);
        chk("rel/valid", txv, 0);
        @(posedge clock); #1;
        chk("rel/ready_edge", rr, 1);
        chk("rel/ready8_edge", rr8, 1);
        chk("rel/busy", busy, 0);

        run_frame(16'h00A5, 3'd3, -1, 0, -1, 16'h0, 3'd0, "basic");
        repeat (2) @(posedge clock);
        #1;
        run_frame(16'hBEEF, 3'd7, 5, 5, -1, 16'h0, 3'd0, "stall");

        // Second result offered mid-frame, then taken in DONE
        run_frame(16'h5A0C, 3'd6, -1, 0, 2, 16'h1234, 3'd1, "busy");
        run_frame(16'h1234, 3'd1, -1, 0, -1, 16'h0, 3'd0, "queued");

        r = 16'($urandom);
        o = 3'($urandom);
        exp = model(r, o, 16, 1'b1, 1'b1);
        rv = 1'b1; res = r; op = o; txr = 1'b1;
        @(posedge clock); #1;
        rv = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("abort/hex0", txd, exp[3]);
        chk("abort/valid_pre", txv, 1);
        reset = 1'b1;
        #1;
        chk("abort/valid", txv, 0);
        chk("abort/busy", busy, 0);
        chk("abort/ready", rr, 0);
        chk("abort/data", txd, 0);
        chk("abort/done", fd, 0);
        @(posedge clock); #1;
        chk("abort/done_edge", fd, 0);
        reset = 1'b0;
        chk("abort/ready_rel", rr, 0);
        @(posedge clock); #1;
        chk("abort/ready_after", rr, 1);
        chk("abort/no_done", fd, 0);
        run_frame(16'hFFFF, 3'd0, -1, 0, -1, 16'h0, 3'd0, "after_abort");

        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
            run_frame(16'($urandom), 3'($urandom), int'($urandom_range(0, 8)),
                      int'($urandom_range(0, 3)), -1, 16'h0, 3'd0, $sformatf("rand%0d", k));
        end

        for (int k = 0; k < 4; k++) begin
            r8 = (k == 0) ? 8'hC0 : 8'($urandom);
            o  = (k == 0) ? 3'd0 : 3'($urandom);
            exp = model({8'h00, r8}, o, 8, 1'b0, 1'b0);
            got = {};
            rv8 = 1'b1; res8 = r8; op8 = o; txr8 = 1'b1;
            @(posedge clock); #1;
            rv8 = 1'b0;
            cyc = 0;
            while (fd8 !== 1'b1 && cyc < 30) begin
                if (txv8 === 1'b1) got.push_back(txd8);
                @(posedge clock); #1;
                cyc++;
            end
            chk($sformatf("p8_%0d/frame_done", k), fd8, 1);
            chk($sformatf("p8_%0d/cycles", k), cyc, exp.size());
            chk($sformatf("p8_%0d/nbytes", k), got.size(), exp.size());
            for (int i = 0; i < exp.size(); i++) begin
                if (i < got.size()) chk($sformatf("p8_%0d/byte%0d", k, i), got[i], exp[i]);
            end
            chk($sformatf("p8_%0d/ready", k), rr8, 1);
            @(posedge clock); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/result_framer.md
Name: result_framer

Overview:
- Downstream stage between the FSM/ALU result path and the UART transmitter.
- Captures one ALU result plus its opcode and converts it to a fixed ASCII text frame.
- Hands the frame to the UART one byte at a time over a valid/ready handshake, so results are human-readable on the tx pin.
- Frame format: 'R', opcode digit, ':', DATA_W/4 hex digits (MSB nibble first), then optional CR LF.

Parameters:
- DATA_W, 16: result width in bits. Must be a multiple of 4 and at least 4.
- UPPERCASE, 1: selects hex letters. 1 gives 'A'-'F' (0x41-0x46); 0 gives 'a'-'f' (0x61-0x66).
- SEND_CRLF, 1: 1 appends 0x0D 0x0A to each frame; 0 omits them.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- result_valid  in  1  upstream result available.
- result  in  DATA_W  ALU result to format.
- opcode  in  3  opcode that produced the result.
- result_ready  out  1  block can accept a result (registered).
- tx_data  out  8  ASCII byte offered to the UART.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART accepts a byte (driven from ~uart_busy).
- busy  out  1  a frame is in progress.
- frame_done  out  1  one-cycle pulse on the edge after the last byte is accepted.

Behaviour:
- Clock/reset: one clock, `clock`. Reset is `reset`, asynchronous, active-high.
- Reset values: state=IDLE, result_ready=0, tx_valid=0, tx_data=8'h00, busy=0, frame_done=0, capture registers=0.
- result_ready goes to 1 on the first clock edge after reset deasserts.
- Upstream handshake:
  - A result is taken on an edge where result_valid && result_ready.
  - On that edge, result and opcode are latched internally, result_ready drops to 0 and busy rises to 1.
- Downstream handshake:
  - A byte transfers on an edge where tx_valid && tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never drops without a transfer, except on reset.
- States and transitions:
  - IDLE: result_ready=1, tx_valid=0. On capture -> HDR.
  - HDR: tx_data=0x52 'R'. On accept -> OPC.
  - OPC: tx_data=0x30+opcode ('0'..'7'). On accept -> SEP.
  - SEP: tx_data=0x3A ':'. On accept -> HEX, nibble counter = DATA_W/4-1.
  - HEX: tx_data=ascii(result[4*cnt+3:4*cnt]). On accept:
    - if cnt=0 -> CR when SEND_CRLF=1, else -> DONE;
    - otherwise cnt decrements.
  - CR: tx_data=0x0D. On accept -> LF.
  - LF: tx_data=0x0A. On accept -> DONE.
  - DONE: internal one-cycle state. frame_done=1, busy=0, result_ready=1, tx_valid=0. Then -> IDLE.
- Hex digit mapping:
  - nibble 0-9 -> 0x30+n.
  - nibble 10-15 -> 0x41+(n-10) when UPPERCASE=1, 0x61+(n-10) when UPPERCASE=0.
- Latency:
  - The capture edge and the first tx_valid=1 ('R') are one cycle apart, because outputs are registered.
  - With tx_ready held high, one byte transfers per cycle: 9 bytes for DATA_W=16 with CRLF.
- Back-to-back frames: result_ready reasserts in DONE, and a capture in DONE is legal. Minimum gap is one idle cycle between the last byte of a frame and the next 'R'.
- result_valid while busy: not accepted. Upstream must hold its data; the latched frame data is unaffected.
- tx_ready asserted while tx_valid=0: no effect.
- Reset mid-frame: the frame is aborted immediately and tx_valid=0 asynchronously. The partial frame is never resumed, and no frame_done pulse occurs.
- result changing after capture: no effect on the frame in progress.

Decomposition:
- Package jsilicon_pkg holds:
  - the framer state enum (IDLE, HDR, OPC, SEP, HEX, CR, LF, DONE);
  - ASCII constants ASCII_R=8'h52, ASCII_COLON=8'h3A, ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_ZERO=8'h30;
  - the letter bases 8'h41 and 8'h61.
- One combinational sub-module, nibble_to_ascii (4-bit in, 8-bit out, UPPERCASE parameter), used by the HEX state.
- Nibble counter and state register stay in result_framer.

Test Plan:
- Basic frame: reset, result=16'h00A5, opcode=3, one result_valid pulse, tx_ready=1 -> bytes 52 33 3A 30 30 41 35 0D 0A on 9 consecutive cycles; frame_done pulses once; result_ready=1 afterwards.
- UART stall: result=16'hBEEF, opcode=7, tx_ready low for 5 cycles during the 3rd hex digit -> tx_data holds 0x45 with tx_valid=1 throughout; full sequence 52 37 3A 42 45 45 46 0D 0A, with no duplicated or lost bytes.
- Busy rejection: second result 16'h1234 presented at byte 2 of a frame -> result_ready=0 and first frame unaffected; 16'h1234 captured in DONE and emitted as 52 .. 31 32 33 34 0D 0A one idle cycle later.
- Reset mid-frame: assert reset after ':' is accepted -> tx_valid=0 immediately, no frame_done; after release, a new frame for 16'hFFFF starts cleanly with 'R'.
- Parameters: UPPERCASE=0, SEND_CRLF=0, DATA_W=8, result=8'hC0, opcode=0 -> bytes 52 30 3A 63 30, then frame_done.
- Reset values: during and just after reset -> result_ready=0, tx_valid=0, tx_data=00, busy=0; result_ready=1 one edge after release.
